// File: rtl/genius_pkg.sv
// Shared definitions for the Genius input stage: FSM state encodings and default debounce length.
package genius_pkg;

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRA_PRESS = 3'd1,
    ACEITA       = 3'd2,
    ESPERA_SOLTA = 3'd3,
    FILTRA_SOLTA = 3'd4
  } estado_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs, one pair of flops per bit.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Synchronizes and debounces the player buttons; emits one jogada pulse per clean single-button press.
//
// state        | meaning
// OCIOSO       | all buttons released and filtered, waiting for a press
// FILTRA_PRESS | one button held, counting stable samples of cand
// ACEITA       | press accepted, jogada high for this cycle
// ESPERA_SOLTA | waiting for every button to be released
// FILTRA_SOLTA | buttons released, counting stable released samples
module detector_jogada
  import genius_pkg::*;
#(
  parameter int NUM_BOTOES      = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CW              = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  habilita,
  input  logic [NUM_BOTOES-1:0] botoes,
  output logic                  jogada,
  output logic [NUM_BOTOES-1:0] botoes_reg,
  output logic                  db_pressionado,
  output logic [2:0]            db_estado
);

  estado_t               estado, estadoProx;
  logic [NUM_BOTOES-1:0] s, cand, candProx;
  logic [CW-1:0]         cnt, cntProx;
  logic                  sOneHot, cntFim, carregaReg;

  sincronizador_2ff #(.WIDTH(NUM_BOTOES)) uSinc (
    .clock(clock),
    .reset(reset),
    .d    (botoes),
    .q    (s)
  );

  assign sOneHot = (s != '0) && ((s & (s - NUM_BOTOES'(1))) == '0);
  assign cntFim  = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      cand       <= '0;
      cnt        <= '0;
      botoes_reg <= '0;
    end else begin
      estado <= estadoProx;
      cand   <= candProx;
      cnt    <= cntProx;
      // Loaded on the edge entering ACEITA so it is valid together with jogada.
      if (carregaReg) botoes_reg <= cand;
    end
  end

  always_comb begin
    estadoProx = estado;
    candProx   = cand;
    cntProx    = cnt;
    carregaReg = 1'b0;
    case (estado)
      OCIOSO: begin
        if (s != '0) begin
          if (habilita && sOneHot) begin
            estadoProx = FILTRA_PRESS;
            candProx   = s;
            cntProx    = '0;
          end else begin
            estadoProx = ESPERA_SOLTA;
          end
        end
      end
      FILTRA_PRESS: begin
        if (!habilita || s == '0) begin
          estadoProx = OCIOSO;
        end else if (!sOneHot) begin
          estadoProx = ESPERA_SOLTA;
        end else if (s != cand) begin
          candProx = s;
          cntProx  = '0;
        end else if (cntFim) begin
          estadoProx = ACEITA;
          carregaReg = 1'b1;
        end else begin
          cntProx = cnt + 1'b1;
        end
      end
      ACEITA: estadoProx = ESPERA_SOLTA;
      ESPERA_SOLTA: begin
        if (s == '0) begin
          estadoProx = FILTRA_SOLTA;
          cntProx    = '0;
        end
      end
      FILTRA_SOLTA: begin
        if (s != '0) begin
          estadoProx = ESPERA_SOLTA;
        end else if (cntFim) begin
          estadoProx = OCIOSO;
        end else begin
          cntProx = cnt + 1'b1;
        end
      end
      default: estadoProx = OCIOSO;
    endcase
  end

  assign jogada         = (estado == ACEITA);
  assign db_pressionado = |s;
  assign db_estado      = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with a sample-history reference model checked every cycle.
module tb_detector_jogada;

  localparam int DC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] botoes = 4'b0000;
  logic       jogada;
  logic [3:0] botoes_reg;
  logic       db_pressionado;
  logic [2:0] db_estado;

  int total = 0;
  int bad = 0;
  int pulsos = 0;

  detector_jogada #(.NUM_BOTOES(4), .DEBOUNCE_CYCLES(DC), .CW(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .habilita      (habilita),
    .botoes        (botoes),
    .jogada        (jogada),
    .botoes_reg    (botoes_reg),
    .db_pressionado(db_pressionado),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  // Reference model: a press is accepted after DC+1 consecutive identical one-hot synchronized
  // samples with habilita high, starting from a fully released, filtered idle; a release is
  // filtered after DC+1 consecutive all-zero samples. Modes: 0 idle, 1 pressing, 2 accept,
  // 3 held/not allowed, 4 releasing.
  logic [3:0] hist [0:1];
  int         modo;
  int         amostras;
  logic [3:0] mCand, mReg;

  always @(posedge clock or negedge reset) begin
    logic [3:0] sv;
    if (!reset) begin
      hist[0] = '0; hist[1] = '0;
      modo = 0; amostras = 0; mCand = '0; mReg = '0;
    end else begin
      sv = hist[1];
      hist[1] = hist[0];
      hist[0] = botoes;
      if (modo == 0) begin
        if (sv != 0) begin
          if (habilita && $countones(sv) == 1) begin modo = 1; mCand = sv; amostras = 1; end
          else modo = 3;
        end
      end else if (modo == 1) begin
        if (!habilita || sv == 0) modo = 0;
        else if ($countones(sv) != 1) modo = 3;
        else if (sv != mCand) begin mCand = sv; amostras = 1; end
        else begin
          amostras++;
          if (amostras == DC + 1) begin modo = 2; mReg = mCand; end
        end
      end else if (modo == 2) begin
        modo = 3;
      end else if (modo == 3) begin
        if (sv == 0) begin modo = 4; amostras = 1; end
      end else begin
        if (sv != 0) modo = 3;
        else begin
          amostras++;
          if (amostras == DC + 1) modo = 0;
        end
      end
    end
  end

  task automatic check(input string nome, input int atual, input int esperado);
    total++;
    if (atual != esperado) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      check("jogada", int'(jogada), (modo == 2) ? 1 : 0);
      check("botoes_reg", int'(botoes_reg), int'(mReg));
      check("db_estado", int'(db_estado), modo);
      check("db_pressionado", int'(db_pressionado), (hist[1] != 0) ? 1 : 0);
      if (jogada) pulsos++;
    end
  end

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    int p0;
    int lat;
    #12;
    check("reset_jogada", int'(jogada), 0);
    check("reset_reg", int'(botoes_reg), 0);
    check("reset_estado", int'(db_estado), 0);
    @(negedge clock);
    reset = 1'b1;
    habilita = 1'b1;
    ciclos(3);

    // 1: clean press, latency and no auto-repeat
    p0 = pulsos;
    botoes = 4'b0010;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (jogada && lat == 0) lat = k;
    end
    check("t1_latencia", lat, 7);
    check("t1_pulsos", pulsos - p0, 1);
    check("t1_reg", int'(botoes_reg), 4'b0010);
    botoes = 4'b0000;
    ciclos(10);

    // 2: bounce
    p0 = pulsos;
    for (int k = 0; k < 5; k++) begin
      botoes = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      ciclos(2);
    end
    botoes = 4'b0100;
    ciclos(20);
    check("t2_pulsos", pulsos - p0, 1);
    check("t2_reg", int'(botoes_reg), 4'b0100);
    botoes = 4'b0000;
    ciclos(10);

    // 3: two buttons together
    p0 = pulsos;
    botoes = 4'b1001;
    ciclos(20);
    check("t3_pulsos", pulsos - p0, 0);
    check("t3_estado", int'(db_estado), 3);
    check("t3_reg", int'(botoes_reg), 4'b0100);
    botoes = 4'b0000;
    ciclos(10);

    // 4: held while habilita rises
    p0 = pulsos;
    habilita = 1'b0;
    botoes = 4'b0001;
    ciclos(5);
    habilita = 1'b1;
    ciclos(15);
    check("t4_sem_pulso", pulsos - p0, 0);
    botoes = 4'b0000;
    ciclos(10);
    botoes = 4'b0001;
    ciclos(15);
    check("t4_pulsos", pulsos - p0, 1);
    check("t4_reg", int'(botoes_reg), 4'b0001);
    botoes = 4'b0000;
    ciclos(10);

    // 5: asynchronous reset in the middle of press filtering
    p0 = pulsos;
    botoes = 4'b1000;
    ciclos(4);
    check("t5_filtrando", int'(db_estado), 1);
    #2 reset = 1'b0;
    habilita = 1'b0;
    #1;
    check("t5_rst_estado", int'(db_estado), 0);
    check("t5_rst_reg", int'(botoes_reg), 0);
    check("t5_rst_jogada", int'(jogada), 0);
    ciclos(2);
    reset = 1'b1;
    ciclos(8);
    habilita = 1'b1;
    ciclos(10);
    check("t5_sem_pulso", pulsos - p0, 0);
    botoes = 4'b0000;
    ciclos(10);
    check("t5_pos_solta", pulsos - p0, 0);

    // 6: back-to-back presses, then a too-short release
    p0 = pulsos;
    botoes = 4'b1000;
    ciclos(12);
    check("t6_reg_a", int'(botoes_reg), 4'b1000);
    botoes = 4'b0000;
    ciclos(6);
    botoes = 4'b0010;
    ciclos(12);
    check("t6_pulsos", pulsos - p0, 2);
    check("t6_reg_b", int'(botoes_reg), 4'b0010);
    botoes = 4'b0000;
    ciclos(3);
    botoes = 4'b1000;
    ciclos(12);
    check("t6_curta", pulsos - p0, 2);
    check("t6_reg_mantido", int'(botoes_reg), 4'b0010);
    botoes = 4'b0000;
    ciclos(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
